// File: rtl/store_ctrl_pkg.sv
// Shared types and constants for the store write controller and its lane merger.
package store_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } store_state_e;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Read-latency counter width; RD_LAT is limited to 1..4.
  localparam int CNT_W = 2;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: replaces the selected byte/half of old_word.
module store_lane_merge
  import store_ctrl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  store_type_e st_type,
  input  logic [1:0]  offset,
  output logic [31:0] merged_word
);

  logic [4:0]  shift_s;
  logic [31:0] mask_s;

  // Lane mask and shift derived from store size and byte offset.
  always_comb begin
    shift_s     = 5'd0;
    mask_s      = 32'h0000_0000;
    merged_word = old_word;
    case (st_type)
      ST_SW: begin
        merged_word = new_data;
      end
      ST_SH: begin
        shift_s     = {offset[1], 4'b0000};
        mask_s      = HALF_MASK << shift_s;
        merged_word = (old_word & ~mask_s) | ((new_data & HALF_MASK) << shift_s);
      end
      ST_SB: begin
        shift_s     = {offset, 3'b000};
        mask_s      = BYTE_MASK << shift_s;
        merged_word = (old_word & ~mask_s) | ((new_data & BYTE_MASK) << shift_s);
      end
      default: begin
        merged_word = old_word;
      end
    endcase
  end

endmodule

// File: rtl/store_write_ctrl.sv
// SW/SH/SB store sequencer for a single-port word memory (RMW for SH/SB).
// Optional alignment trap enabled by defining MISALIGN_TRAP_EN.
module store_write_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  store_state_e     state_r, state_s;
  store_type_e      type_r, type_s, req_type_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      data_r, data_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      merged_s;
  logic             fault_s;

  logic [31:0]      mem_addr_r, mem_addr_s;
  logic [31:0]      mem_wdata_r, mem_wdata_s;
  logic             mem_wr_r, mem_wr_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             misalign_r, misalign_s;

  assign req_type_s = store_type_e'(store_type);

`ifdef MISALIGN_TRAP_EN
  assign fault_s = ((req_type_s == ST_SW) && (addr[1:0] != 2'b00)) ||
                   ((req_type_s == ST_SH) && addr[0]);
`else
  assign fault_s = 1'b0;
`endif

  store_lane_merge u_merge (
    .old_word    (mem_rdata),
    .new_data    (data_r),
    .st_type     (type_r),
    .offset      (addr_r[1:0]),
    .merged_word (merged_s)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_s = state_r;
    type_s  = type_r;
    addr_s  = addr_r;
    data_s  = data_r;
    wdata_s = wdata_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start && (req_type_s != ST_RSV)) begin
          type_s = req_type_s;
          addr_s = addr;
          data_s = wr_data;
          if (fault_s) begin
            state_s = FAULT;
          end else if (req_type_s == ST_SW) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
            cnt_s   = CNT_W'(RD_LAT - 32'd1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s = MERGE;
        end
      end
      MERGE: begin
        wdata_s = merged_s;
        state_s = WRITE;
      end
      WRITE:   state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they register cleanly.
  always_comb begin
    mem_addr_s  = {addr_s[31:2], 2'b00};
    mem_wr_s    = (state_s == WRITE);
    done_s      = (state_s == WRITE) || (state_s == FAULT);
    busy_s      = (state_s != IDLE);
    misalign_s  = (state_s == FAULT);
    mem_wdata_s = 32'h0000_0000;
    if (state_s == WRITE) begin
      if (type_s == ST_SW) begin
        mem_wdata_s = data_s;
      end else begin
        mem_wdata_s = wdata_s;
      end
    end else begin
      mem_wdata_s = 32'h0000_0000;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      type_r      <= ST_SW;
      addr_r      <= 32'h0000_0000;
      data_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      cnt_r       <= {CNT_W{1'b0}};
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      type_r      <= type_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      wdata_r     <= wdata_s;
      cnt_r       <= cnt_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wr_r    <= mem_wr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      misalign_r  <= misalign_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wr    = mem_wr_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef MISALIGN_TRAP_EN
  assign misalign  = misalign_r;
`else
  assign misalign  = 1'b0;
`endif

endmodule
